// File: rtl/image_write_pkg.sv
// Shared defaults and FSM encoding for the raster capture path.
package image_write_pkg;

   localparam int WIDTH_DEF    = 768;
   localparam int DEPTH_DEF    = 512;
   localparam int ADDRSIZE_DEF = 393216;
   localparam int ADDRW_DEF    = 19;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LINE = 2'd1,
      LINE      = 2'd2,
      DONE      = 2'd3
   } state_t;

endpackage

// File: rtl/image_write_frame_buffer.sv
// Single write port, registered read port; a same-cycle read of the written
// address returns the previous contents.
module frame_buffer
   import image_write_pkg::*;
#(
   parameter int ADDRSIZE = ADDRSIZE_DEF,
   parameter int ADDRW    = ADDRW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [ADDRW-1:0] wr_addr,
   input  logic [7:0]       wr_data,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [7:0]       rd_data
);

   logic [7:0] mem [ADDRSIZE];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/image_write.sv
// Frame-capture sink: tracks row/column of the VSYNC/HSYNC pixel stream and
// stores each valid pixel at row*WIDTH+col, flagging short lines and aborts.
module image_write
   import image_write_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDRSIZE = ADDRSIZE_DEF,
   parameter int ADDRW    = ADDRW_DEF
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             VSYNC,
   input  logic             HSYNC,
   input  logic [7:0]       data,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             frame_done,
   output logic [9:0]       row,
   output logic             err_short,
   output logic             err_abort
);

   localparam int COLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [COLW-1:0] LAST_COL = COLW'(WIDTH - 1);
   localparam logic [9:0]      LAST_ROW = 10'(DEPTH - 1);

   state_t            state, next_state;
   logic              vs_d;
   logic [COLW-1:0]   col;
   logic              wr_en;
   logic [ADDRW-1:0]  wr_addr;

   logic vs_rise, in_frame, line_end, short_end, last_row;

   assign vs_rise   = VSYNC & ~vs_d;
   assign in_frame  = (state == WAIT_LINE) || (state == LINE);
   assign last_row  = (row == LAST_ROW);
   assign line_end  = HSYNC & (col == LAST_COL);
   assign short_end = ~HSYNC & (state == LINE) & (col != '0);
   assign wr_addr   = ADDRW'(row) * ADDRW'(WIDTH) + ADDRW'(col);

   always_ff @(posedge HCLK) begin
      if (HRESET)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (vs_rise) next_state = WAIT_LINE;
         WAIT_LINE: begin
            if (vs_rise)    next_state = WAIT_LINE;
            else if (HSYNC) next_state = LINE;
         end
         LINE: begin
            if (vs_rise)
               next_state = WAIT_LINE;
            else if (line_end || short_end)
               next_state = last_row ? DONE : WAIT_LINE;
         end
         DONE:      next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // A restarting VSYNC edge or reset wins over the pixel in the same cycle.
   always_comb begin
      busy  = in_frame;
      wr_en = in_frame & HSYNC & ~vs_rise & ~HRESET;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         vs_d       <= 1'b0;
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
         err_short  <= 1'b0;
         err_abort  <= 1'b0;
      end else begin
         vs_d       <= VSYNC;
         frame_done <= 1'b0;
         if (state == IDLE) begin
            if (vs_rise) begin
               col       <= '0;
               row       <= '0;
               err_short <= 1'b0;
               err_abort <= 1'b0;
            end
         end else if (in_frame) begin
            if (vs_rise) begin
               err_abort <= 1'b1;
               col       <= '0;
               row       <= '0;
            end else if (line_end) begin
               col <= '0;
               if (last_row)
                  frame_done <= 1'b1;
               else
                  row <= row + 10'd1;
            end else if (HSYNC) begin
               col <= col + COLW'(1);
            end else if (short_end) begin
               err_short <= 1'b1;
               col       <= '0;
               if (!last_row)
                  row <= row + 10'd1;
            end
         end
      end
   end

   frame_buffer #(
      .ADDRSIZE (ADDRSIZE),
      .ADDRW    (ADDRW)
   ) u_frame_buffer (
      .clk     (HCLK),
      .reset   (HRESET),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_image_write.sv
// Bench for image_write on a 4x3 frame: readback scoreboard plus direct
// checks of frame_done, error flags, reset and read/write collision.
module tb_image_write;

   localparam int W  = 4;
   localparam int D  = 3;
   localparam int N  = 12;
   localparam int AW = 4;

   typedef struct {
      int         addr;
      logic [7:0] data;
   } rd_item_t;

   logic          HCLK = 1'b0;
   logic          HRESET, VSYNC, HSYNC;
   logic [7:0]    data;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          busy, frame_done, err_short, err_abort;
   logic [9:0]    row;

   int         checks = 0;
   int         errors = 0;
   int         fd_count = 0;
   logic [7:0] exp_mem [N];
   rd_item_t   sb_q [$];

   image_write #(
      .WIDTH    (W),
      .DEPTH    (D),
      .ADDRSIZE (N),
      .ADDRW    (AW)
   ) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .VSYNC      (VSYNC),
      .HSYNC      (HSYNC),
      .data       (data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .frame_done (frame_done),
      .row        (row),
      .err_short  (err_short),
      .err_abort  (err_abort)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) if (frame_done === 1'b1) fd_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic vsync_pulse();
      VSYNC = 1'b1;
      tick();
      VSYNC = 1'b0;
      tick();
   endtask

   task automatic send_line(input logic [7:0] base, input int n, input int first_addr);
      for (int i = 0; i < n; i++) begin
         HSYNC = 1'b1;
         data  = 8'(base + i);
         exp_mem[first_addr + i] = 8'(base + i);
         tick();
      end
      HSYNC = 1'b0;
   endtask

   // Called right after the edge that wrote the last pixel.
   task automatic frame_end_checks(input string tag, input int fd_before);
      check({tag, "_fd_hi"}, frame_done, 1'b1);
      tick();
      check({tag, "_fd_lo"}, frame_done, 1'b0);
      check({tag, "_fd_cnt"}, fd_count - fd_before, 1);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   task automatic send_frame(input string tag, input logic [7:0] base, input int gap);
      int fd0;
      fd0 = fd_count;
      vsync_pulse();
      check({tag, "_busy_start"}, busy, 1'b1);
      for (int l = 0; l < D; l++) begin
         send_line(8'(base + 4 * l), W, W * l);
         if (l < D - 1) idle(gap);
      end
      frame_end_checks(tag, fd0);
   endtask

   task automatic readback(input int lo, input int hi);
      rd_item_t it;
      for (int a = lo; a <= hi; a++) begin
         rd_addr = AW'(a);
         sb_q.push_back('{a, exp_mem[a]});
         tick();
         it = sb_q.pop_front();
         check($sformatf("rd_addr%0d", it.addr), rd_data, it.data);
      end
   endtask

   initial begin
      int fd0;
      HRESET = 1'b1; VSYNC = 1'b0; HSYNC = 1'b0; data = '0; rd_addr = '0;
      idle(2);
      HRESET = 1'b0;
      check("rst_busy", busy, 1'b0);
      check("rst_fd", frame_done, 1'b0);
      check("rst_row", row, 10'd0);
      check("rst_errs", {err_short, err_abort}, 2'b00);
      check("rst_rd", rd_data, 8'h00);
      idle(2);

      // Nominal frame, 5 idle cycles between lines
      fd0 = fd_count;
      vsync_pulse();
      send_line(8'h10, W, 0);
      check("nom_row1", row, 10'd1);
      idle(5);
      send_line(8'h14, W, 4);
      idle(5);
      send_line(8'h18, W, 8);
      frame_end_checks("nom", fd0);
      check("nom_errs", {err_short, err_abort}, 2'b00);
      readback(0, N - 1);

      // Short line 1
      fd0 = fd_count;
      vsync_pulse();
      send_line(8'h30, W, 0);
      idle(2);
      send_line(8'h34, 2, 4);
      idle(2);
      check("short_err", err_short, 1'b1);
      check("short_row", row, 10'd2);
      send_line(8'h38, W, 8);
      frame_end_checks("short", fd0);
      check("short_abort", err_abort, 1'b0);
      readback(0, N - 1);

      // Mid-frame abort during line 1; the colliding pixel is dropped
      vsync_pulse();
      send_line(8'h40, W, 0);
      idle(2);
      send_line(8'h44, 2, 4);
      HSYNC = 1'b1; data = 8'h99; VSYNC = 1'b1;
      tick();
      HSYNC = 1'b0; VSYNC = 1'b0;
      check("abort_err", err_abort, 1'b1);
      check("abort_row", row, 10'd0);
      check("abort_busy", busy, 1'b1);
      readback(6, 6);
      fd0 = fd_count;
      for (int l = 0; l < D; l++) begin
         send_line(8'(8'h20 + 4 * l), W, W * l);
         if (l < D - 1) idle(2);
      end
      frame_end_checks("abort", fd0);
      check("abort_sticky", err_abort, 1'b1);
      check("abort_short", err_short, 1'b0);
      readback(0, N - 1);
      vsync_pulse();
      check("abort_clear", err_abort, 1'b0);

      // Reset during line 2 (vsync from WAIT_LINE re-raises err_abort first)
      fd0 = fd_count;
      vsync_pulse();
      send_line(8'h70, W, 0);
      idle(2);
      send_line(8'h74, 2, 4);
      idle(2);
      send_line(8'h78, 2, 8);
      check("pre_rst_errs", {err_short, err_abort}, 2'b11);
      rd_addr = AW'(3);
      HSYNC = 1'b1; data = 8'h7A; HRESET = 1'b1;
      tick();
      HSYNC = 1'b0; HRESET = 1'b0;
      check("mrst_busy", busy, 1'b0);
      check("mrst_fd", frame_done, 1'b0);
      check("mrst_row", row, 10'd0);
      check("mrst_errs", {err_short, err_abort}, 2'b00);
      check("mrst_rd", rd_data, 8'h00);
      idle(3);
      check("mrst_nofd", fd_count - fd0, 0);
      readback(0, N - 1);
      send_frame("post_rst", 8'h50, 2);
      readback(0, N - 1);

      // One-cycle gaps; collision on addr 0 during its write
      fd0 = fd_count;
      rd_addr = '0;
      vsync_pulse();
      HSYNC = 1'b1; data = 8'h60;
      tick();
      check("coll_old", rd_data, 8'h50);
      exp_mem[0] = 8'h60;
      for (int i = 1; i < W; i++) begin
         data = 8'(8'h60 + i);
         exp_mem[i] = data;
         tick();
         if (i == 1) check("coll_new", rd_data, 8'h60);
      end
      HSYNC = 1'b0;
      idle(1);
      send_line(8'h64, W, 4);
      idle(1);
      send_line(8'h68, W, 8);
      frame_end_checks("zgap", fd0);
      check("zgap_errs", {err_short, err_abort}, 2'b00);
      readback(0, N - 1);

      check("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
